if_fetch_q: RTL and testbench
=============================

IF_FETCH_Q -- requirements
Module: if_fetch_q

Interface
REQ-001 Parameter PC_W, default 32: fetch address width.
REQ-002 Parameter INST_W, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: fetch address after reset.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_  input  1  reset; synchronous, active-low.
REQ-007 pc  output  PC_W  instruction memory fetch address.
REQ-008 pc_vld  output  1  fetch request valid this cycle.
REQ-009 inst_data  input  INST_W  memory read data, valid exactly one cycle after its pc_vld.
REQ-010 id_pc  output  PC_W  address of the head instruction.
REQ-011 id_inst  output  INST_W  head instruction.
REQ-012 id_vld  output  1  head entry valid.
REQ-013 id_stall  input  1  decode not accepting; head popped when id_vld=1 and id_stall=0.
REQ-014 br_taken  input  1  redirect request from execute.
REQ-015 br_target  input  PC_W  redirect address; bits [1:0] treated as zero.

Function
REQ-016 Internal state: PC register, DEPTH-entry {pc, inst} circular queue, head/tail pointers, count (0..DEPTH), 1-bit inflight flag equal to last cycle's pc_vld.
REQ-017 pc_vld = rst_ high and br_taken low and (count + inflight) < DEPTH; a same-cycle pop does not free space for issue.
REQ-018 On a pc_vld cycle the PC advances by 4 at the edge, wrapping modulo 2^PC_W.
REQ-019 In the cycle after an issue, inst_data and the issued address are written at the tail at the closing edge; tail wraps modulo DEPTH.
REQ-020 id_vld = (count != 0); id_pc/id_inst drive the head entry combinationally from stored state; no empty-queue bypass.
REQ-021 Latency: issue in cycle t gives id_vld in cycle t+2 when the queue was empty.
REQ-022 Simultaneous write and pop: count unchanged, both pointers advance.
REQ-023 Overflow impossible by REQ-017; a write into a full queue is a design error, flagged by a bench assertion.
REQ-024 Pop when empty or stalled: no state change; head entry held stable while id_stall=1.
REQ-025 br_taken in cycle t: pc_vld forced 0 in t; at the edge count, head and tail cleared and inflight cleared; any response arriving in t discarded; PC loaded with {br_target[PC_W-1:2], 2'b00}.
REQ-026 br_taken has priority over same-cycle pop and write; id_vld is 0 in cycle t+1; first fetch of target issues in t+1.
REQ-027 Back-to-back br_taken cycles: each applies; last target wins.

Reset
REQ-028 While rst_=0 at an edge: PC=RESET_PC, count=0, pointers=0, inflight=0.
REQ-029 During reset pc_vld=0, id_vld=0; pc=RESET_PC; id_pc/id_inst don't-care.
REQ-030 Reset mid-operation discards all queued and in-flight instructions; first issue is the cycle after rst_ rises.

Configuration
REQ-031 Macro IF_FETCH_Q_PERF_CNT_EN, when defined, adds outputs fetch_cnt (32 bits, +1 per queue write) and flush_cnt (32 bits, +1 per br_taken cycle), both zero on reset and wrapping at 2^32.
REQ-032 Without IF_FETCH_Q_PERF_CNT_EN the ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Reset release, RESET_PC=0, id_stall=0, memory returns addr+0x100 -> pc 0,4,8,... on consecutive cycles; id_vld first in cycle 2 with id_pc=0, id_inst=0x100.
REQ-034 DEPTH=4, id_stall=1 held -> exactly 4 issues (pc 0..0xC); pc_vld low with pc=0x10 while full; one unstalled pop -> pc_vld high next cycle.
REQ-035 br_taken=1, br_target=0x203, with a pop and a response in the same cycle -> next cycle id_vld=0, pc=0x200, pc_vld=1; two cycles later id_pc=0x200.
REQ-036 rst_ driven low for 1 cycle with 3 entries queued -> id_vld=0, pc=RESET_PC; refetch from RESET_PC; no stale instruction emitted.
REQ-037 PC_W=8, RESET_PC=0xF8 -> pc sequence 0xF8,0xFC,0x00 with queue order preserved.
REQ-038 IF_FETCH_Q_PERF_CNT_EN defined, 10 writes and 2 flushes -> fetch_cnt=10, flush_cnt=2; discarded responses not counted.

Source files
------------

// File: rtl/if_fetch_q.sv
// if_fetch_q: instruction fetch unit with a small prefetch queue.
//
// The fetch PC advances by 4 on every issued request. Each response comes
// back one cycle after its request and is stored with its address in a
// DEPTH-entry circular queue. Decode pops the head of the queue. A branch
// redirect flushes the queue and any request still in flight, then restarts
// fetching at the target.
//
// Parameters
//   PC_W      fetch address width (at least 3)
//   INST_W    instruction width
//   DEPTH     queue entries; must be a power of two, at least 2
//   RESET_PC  fetch address after reset
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst_        synchronous active-low reset
//   pc          fetch address to instruction memory
//   pc_vld      fetch request valid this cycle
//   inst_data   memory read data, valid one cycle after its pc_vld
//   id_pc       address of the head instruction
//   id_inst     head instruction
//   id_vld      head entry valid
//   id_stall    decode not accepting; head is popped when id_vld && !id_stall
//   br_taken    redirect request from execute
//   br_target   redirect address; bits [1:0] are ignored
//   fetch_cnt   (IF_FETCH_Q_PERF_CNT_EN only) number of queue writes
//   flush_cnt   (IF_FETCH_Q_PERF_CNT_EN only) number of br_taken cycles
//
// Optional feature: define IF_FETCH_Q_PERF_CNT_EN to add the two 32-bit
// performance counters. Without it the counter ports do not exist.

module if_fetch_q #(
    parameter int              PC_W     = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_,
    output logic [PC_W-1:0]   pc,
    output logic              pc_vld,
    input  logic [INST_W-1:0] inst_data,
    output logic [PC_W-1:0]   id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic              id_vld,
    input  logic              id_stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target
`ifdef IF_FETCH_Q_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W+1)'(DEPTH);

    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   infl_pc_q;
    logic              infl_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [PC_W-1:0]   q_pc   [DEPTH];
    logic [INST_W-1:0] q_inst [DEPTH];

    logic [CNT_W:0]    occ;
    logic              issue;
    logic              wr;
    logic              pop;
    logic              unused_br_lsb;

    // Space is reserved for the in-flight response as well as stored
    // entries, so a response always has a slot when it lands. A pop in the
    // same cycle deliberately does not count as free space.
    assign occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, infl_q};
    assign issue = rst_ && !br_taken && (occ < DEPTH_OCC);
    assign wr    = infl_q && !br_taken;
    assign pop   = (count_q != '0) && !id_stall && !br_taken;

    assign pc      = rst_ ? pc_q : RESET_PC;
    assign pc_vld  = issue;
    assign id_vld  = rst_ && (count_q != '0);
    assign id_pc   = q_pc[head_q];
    assign id_inst = q_inst[head_q];

    assign unused_br_lsb = ^br_target[1:0];

    always_ff @(posedge clk) begin
        if (!rst_) begin
            pc_q      <= RESET_PC;
            infl_pc_q <= RESET_PC;
            infl_q    <= 1'b0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else if (br_taken) begin
            // Redirect wins over any pop or write in the same cycle; the
            // response arriving now belongs to the old path and is dropped.
            pc_q    <= {br_target[PC_W-1:2], 2'b00};
            infl_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (issue) begin
                pc_q <= pc_q + PC_W'(4);
            end
            infl_q    <= issue;
            infl_pc_q <= pc_q;
            if (wr) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({wr, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Queue storage has no reset; validity is carried entirely by count_q.
    always_ff @(posedge clk) begin
        if (rst_ && wr) begin
            q_pc[tail_q]   <= infl_pc_q;
            q_inst[tail_q] <= inst_data;
        end
    end

`ifdef IF_FETCH_Q_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (wr) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (br_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_q.sv
// tb_if_fetch_q: self-checking bench for if_fetch_q.
//
// A queue-based reference model tracks the fetch PC, the one outstanding
// request and the stored {pc, inst} entries; every cycle the DUT outputs
// are compared against it. Directed phases cover reset, streaming, queue
// full, branch flush and mid-run reset, followed by randomized traffic.
// A second instance with PC_W=8 and RESET_PC=0xF8 checks address wrap.

module tb_if_fetch_q;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_;
    logic [31:0] pc;
    logic        pc_vld;
    logic [31:0] inst_data;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_vld;
    logic        id_stall;
    logic        br_taken;
    logic [31:0] br_target;
`ifdef IF_FETCH_Q_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] fetch_cnt8;
    logic [31:0] flush_cnt8;
`endif

    logic [7:0]  pc8;
    logic        pc_vld8;
    logic [31:0] inst8;
    logic [7:0]  id_pc8;
    logic [31:0] id_inst8;
    logic        id_vld8;
    logic        id_stall8;
    logic        br_taken8;
    logic [7:0]  br_target8;

    if_fetch_q #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .pc        (pc),
        .pc_vld    (pc_vld),
        .inst_data (inst_data),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_vld    (id_vld),
        .id_stall  (id_stall),
        .br_taken  (br_taken),
        .br_target (br_target)
`ifdef IF_FETCH_Q_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    if_fetch_q #(.PC_W(8), .INST_W(32), .DEPTH(4), .RESET_PC(8'hF8)) dut8 (
        .clk       (clk),
        .rst_      (rst_),
        .pc        (pc8),
        .pc_vld    (pc_vld8),
        .inst_data (inst8),
        .id_pc     (id_pc8),
        .id_inst   (id_inst8),
        .id_vld    (id_vld8),
        .id_stall  (id_stall8),
        .br_taken  (br_taken8),
        .br_target (br_target8)
`ifdef IF_FETCH_Q_PERF_CNT_EN
        ,
        .fetch_cnt (fetch_cnt8),
        .flush_cnt (flush_cnt8)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;
    bit          seen_reset;

    logic [31:0] mem_salt;
    bit          p_vld;
    logic [31:0] p_addr;
    bit          p8_vld;
    logic [7:0]  p8_addr;

    bit          cur_r, cur_stall, cur_br;
    logic [31:0] cur_tgt;
    bit          e_vld, e_idv;
    logic [31:0] e_pc;
    logic [7:0]  e8;
    int          n_iss;
    bit          reached;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a + 32'h100) ^ mem_salt;
    endfunction

    task automatic drive(input bit r, input bit stall, input bit br, input logic [31:0] tgt);
        @(negedge clk);
        inst_data = p_vld  ? mem(p_addr) : $urandom();
        inst8     = p8_vld ? (32'h100 + {24'h0, p8_addr}) : $urandom();
        rst_      = r;
        id_stall  = stall;
        br_taken  = br;
        br_target = tgt;
        cur_r     = r;
        cur_stall = stall;
        cur_br    = br;
        cur_tgt   = tgt;
        #1;
        e_pc  = r ? m_pc : 32'h0;
        e_vld = r && !br && ((mq.size() + int'(m_infl)) < DEPTH);
        e_idv = r && (mq.size() != 0);
        check("pc", pc, e_pc);
        check("pc_vld", pc_vld, e_vld);
        check("id_vld", id_vld, e_idv);
        if (e_idv) begin
            check("id_pc", id_pc, mq[0].pc);
            check("id_inst", id_inst, mq[0].inst);
        end
`ifdef IF_FETCH_Q_PERF_CNT_EN
        if (seen_reset) begin
            check("fetch_cnt", fetch_cnt, m_fetch);
            check("flush_cnt", flush_cnt, m_flush);
        end
`endif
        p8_vld  = pc_vld8;
        p8_addr = pc8;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!cur_r) begin
            mq.delete();
            m_pc       = 32'h0;
            m_infl     = 1'b0;
            m_fetch    = 32'h0;
            m_flush    = 32'h0;
            seen_reset = 1'b1;
        end else if (cur_br) begin
            mq.delete();
            m_infl  = 1'b0;
            m_pc    = cur_tgt & ~32'h3;
            m_flush = m_flush + 32'd1;
        end else begin
            if (mq.size() != 0 && !cur_stall) begin
                void'(mq.pop_front());
            end
            if (m_infl) begin
                check("no_overflow", mq.size() < DEPTH, 1'b1);
                mq.push_back('{m_infl_pc, inst_data});
                m_fetch = m_fetch + 32'd1;
            end
            m_infl    = e_vld;
            m_infl_pc = m_pc;
            if (e_vld) begin
                m_pc = m_pc + 32'd4;
            end
        end
        p_vld  = e_vld;
        p_addr = e_pc;
    endtask

    task automatic step(input bit r, input bit stall, input bit br, input logic [31:0] tgt);
        drive(r, stall, br, tgt);
        advance();
    endtask

    initial begin
        rst_ = 1'b0; id_stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
        inst_data = 32'h0; inst8 = 32'h0;
        id_stall8 = 1'b0; br_taken8 = 1'b0; br_target8 = 8'h0;
        mem_salt = 32'h0; p_vld = 1'b0; p_addr = 32'h0; p8_vld = 1'b0; p8_addr = 8'h0;
        m_pc = 32'h0; m_infl = 1'b0; m_infl_pc = 32'h0;
        m_fetch = 32'h0; m_flush = 32'h0; seen_reset = 1'b0;

        // reset
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            check("rst_pc", pc, 32'h0);
            check("rst_pc_vld", pc_vld, 1'b0);
            check("rst_id_vld", id_vld, 1'b0);
            check("rst_pc8", pc8, 8'hF8);
            advance();
        end

        // streaming from reset, plus PC wrap on the 8-bit instance
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            check("seq_pc", pc, 32'(4 * k));
            check("seq_pc_vld", pc_vld, 1'b1);
            check("seq_id_vld", id_vld, k >= 2);
            if (k == 2) begin
                check("first_id_pc", id_pc, 32'h0);
                check("first_id_inst", id_inst, 32'h100);
            end
            if (k < 3) begin
                e8 = 8'hF8 + 8'(4 * k);
                check("pc8", pc8, e8);
            end
            if (k >= 2 && k < 5) begin
                e8 = 8'hF8 + 8'(4 * (k - 2));
                check("id_vld8", id_vld8, 1'b1);
                check("id_pc8", id_pc8, e8);
                check("id_inst8", id_inst8, 32'h100 + {24'h0, e8});
            end
            advance();
        end

        // fill with decode stalled
        step(1'b0, 1'b1, 1'b0, 32'h0);
        n_iss = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            if (pc_vld) n_iss++;
            advance();
        end
        check("full_issues", n_iss, 4);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("full_pc", pc, 32'h10);
        check("full_pc_vld", pc_vld, 1'b0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("pop_no_issue", pc_vld, 1'b0);
        advance();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        check("pop_frees", pc_vld, 1'b1);
        advance();

        // branch with same-cycle pop and response
        drive(1'b1, 1'b0, 1'b1, 32'h203);
        check("br_pc_vld", pc_vld, 1'b0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("br_id_vld", id_vld, 1'b0);
        check("br_pc", pc, 32'h200);
        check("br_fetch", pc_vld, 1'b1);
        advance();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("br_head_vld", id_vld, 1'b1);
        check("br_head_pc", id_pc, 32'h200);
        advance();

        // back-to-back branches
        step(1'b1, 1'b0, 1'b1, 32'h300);
        step(1'b1, 1'b0, 1'b1, 32'h405);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("b2b_pc", pc, 32'h404);
        advance();

        // reset with entries queued
        reached = 1'b0;
        for (int k = 0; k < 12 && !reached; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (mq.size() == 3) reached = 1'b1;
        end
        check("three_queued", reached, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        check("mid_rst_id_vld", id_vld, 1'b0);
        check("mid_rst_pc", pc, 32'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("refetch_pc", pc, 32'h0);
        check("refetch_vld", pc_vld, 1'b1);
        check("no_stale", id_vld, 1'b0);
        advance();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        check("refetch_head", id_pc, 32'h0);
        advance();

        // randomized traffic
        mem_salt = $urandom();
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 6,
                 $urandom());
        end

`ifdef IF_FETCH_Q_PERF_CNT_EN
        check("flush_cnt8", flush_cnt8, 32'h0);
        check("fetch_cnt8_nz", fetch_cnt8 != 32'h0, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
